slave_r_buffer_i: RTL
=====================

// Module: slave_r_buffer_i
// PURPOSE
// - AXI4 read-data (R) channel return-path buffer: accepts R beats from the downstream master port, presents them to the upstream slave port.
// - Pairs with the AR-channel buffer: AR flows slave->master, R flows master->slave.
// - Provides a BUFF_DEPTH-entry FIFO, a sticky error flag and a completed-burst counter.
// - Breaks the ready path: no combinational path from slave_ready_i to master_ready_o.
// PARAMETERS
// - DATA_WIDTH  64  R data width in bits
// - ID_WIDTH    16  RID width
// - USER_WIDTH  10  RUSER width
// - BUFF_DEPTH   4  FIFO entries; power of two, >= 2
// PORTS
// - clk_i             in   1           single clock, all logic on posedge
// - rst_i             in   1           synchronous reset, active-high
// - master_valid_i    in   1           RVALID from downstream
// - master_data_i     in   DATA_WIDTH  RDATA
// - master_resp_i     in   2           RRESP
// - master_last_i     in   1           RLAST
// - master_id_i       in   ID_WIDTH    RID
// - master_user_i     in   USER_WIDTH  RUSER
// - master_ready_o    out  1           RREADY to downstream
// - slave_valid_o     out  1           RVALID to upstream
// - slave_data_o      out  DATA_WIDTH  head-entry RDATA
// - slave_resp_o      out  2           head-entry RRESP
// - slave_last_o      out  1           head-entry RLAST
// - slave_id_o        out  ID_WIDTH    head-entry RID
// - slave_user_o      out  USER_WIDTH  head-entry RUSER
// - slave_ready_i     in   1           RREADY from upstream
// - count_o           out  $clog2(BUFF_DEPTH+1)  current occupancy
// - err_o             out  1           sticky: a SLVERR or DECERR beat was accepted
// - err_clr_i         in   1           clears err_o
// - bursts_done_o     out  16          count of popped beats with RLAST=1; wraps
// BEHAVIOUR
// - Reset (rst_i=1 at posedge): count, pointers, err_o, bursts_done_o and all storage entries go to 0.
//   - Outputs during and after reset: slave_valid_o=0, payload outputs 0, master_ready_o=0.
//   - master_ready_o=1 from the first cycle after rst_i deasserts.
//   - Reset mid-burst discards all stored beats; no partial output.
// - Push: master_valid_i & master_ready_o at posedge. Writes the entry at wr_ptr, wr_ptr+1 (wraps mod BUFF_DEPTH).
// - Pop: slave_valid_o & slave_ready_i at posedge. rd_ptr+1 (wraps).
// - master_ready_o = (count != BUFF_DEPTH). Driven from registered count only.
// - slave_valid_o = (count != 0). Payload outputs show the entry at rd_ptr.
// - Latency: a beat pushed at edge N appears on slave_* in the cycle after edge N (1 cycle).
// - Empty: slave_valid_o=0. Payload shows a stale entry; it is not checked.
// - Full: master_ready_o=0.
//   - A pop at edge N raises master_ready_o in the cycle after edge N.
//   - Full never drops or overwrites a beat.
// - Simultaneous push and pop: count unchanged, both pointers advance.
//   - When count=1 this yields back-to-back output beats at full throughput.
// - AXI stability: once slave_valid_o=1, it and the payload hold until the pop. No upstream-visible reordering; beats leave in arrival order.
// - err_o:
//   - Set on a push with master_resp_i[1]=1 (SLVERR 2'b10, DECERR 2'b11).
//   - Cleared by err_clr_i; a set and a clear in the same cycle leaves err_o=1.
//   - OKAY and EXOKAY beats never set err_o.
// - bursts_done_o: +1 on a pop with slave_last_o=1; 16'hFFFF+1 -> 0.
// STRUCTURE
// - Shared package axi_resp_pkg holds:
//   - RRESP encodings OKAY/EXOKAY/SLVERR/DECERR as 2-bit localparams.
//   - A packed R-beat payload width helper: DATA_WIDTH+2+1+ID_WIDTH+USER_WIDTH.
// - One sub-module, r_buffer_fifo: a generic synchronous FIFO.
//   - Params WIDTH and DEPTH; ports push/pop/wdata/rdata/count/full/empty.
//   - Pointer width $clog2(DEPTH), occupancy width $clog2(DEPTH+1).
// - Top level packs/unpacks the R payload, and owns err_o and bursts_done_o.
// TESTING
// - Reset, then push 1 beat (data=64'hA5, resp=OKAY, last=1, id=3) with slave_ready_i=1
//   -> slave_valid_o=1 one cycle later with the same payload; bursts_done_o=1 after the pop; count returns to 0.
// - Push 4 beats with slave_ready_i=0 (BUFF_DEPTH=4) -> master_ready_o=0 at count=4;
//   a 5th valid beat is held off; raise slave_ready_i -> beats 1..4 then beat 5 come out in order, none lost.
// - Continuous valid on both sides for 32 beats -> one beat per cycle after 1-cycle fill latency; count stays at 1.
// - Push a beat with resp=2'b10 -> err_o=1 on the next cycle and holds through 10 OKAY beats;
//   assert err_clr_i together with a DECERR push -> err_o stays 1; err_clr_i alone -> 0.
// - Assert rst_i with count=3 mid-burst -> next cycle slave_valid_o=0, count_o=0, err_o=0, bursts_done_o=0; master_ready_o=1 after release.
// - Preload bursts_done_o to 16'hFFFF via 65535 last-beats, then pop one more last-beat -> bursts_done_o=0.

Source files
------------

// File: rtl/axi_resp_pkg.sv
// ============================================================================
// axi_resp_pkg : AXI RRESP encodings and R-beat payload width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package axi_resp_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Packed layout: {data, resp[1:0], last, id, user}
   function automatic int r_payload_width(input int data_w, input int id_w, input int user_w);
      return data_w + 2 + 1 + id_w + user_w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/r_buffer_fifo.sv
// ============================================================================
// r_buffer_fifo : generic synchronous FIFO, power-of-two depth
// Rev 1.0
// ============================================================================
`default_nettype none

module r_buffer_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointers wrap naturally because DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/slave_r_buffer_i.sv
// ============================================================================
// slave_r_buffer_i : AXI4 R-channel return buffer with sticky error and burst count
// Rev 1.0
// ============================================================================
`default_nettype none

module slave_r_buffer_i
   import axi_resp_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 16,
   parameter int USER_WIDTH = 10,
   parameter int BUFF_DEPTH = 4,
   localparam int CNT_W     = $clog2(BUFF_DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  master_valid_i,
   input  logic [DATA_WIDTH-1:0] master_data_i,
   input  logic [1:0]            master_resp_i,
   input  logic                  master_last_i,
   input  logic [ID_WIDTH-1:0]   master_id_i,
   input  logic [USER_WIDTH-1:0] master_user_i,
   output logic                  master_ready_o,
   output logic                  slave_valid_o,
   output logic [DATA_WIDTH-1:0] slave_data_o,
   output logic [1:0]            slave_resp_o,
   output logic                  slave_last_o,
   output logic [ID_WIDTH-1:0]   slave_id_o,
   output logic [USER_WIDTH-1:0] slave_user_o,
   input  logic                  slave_ready_i,
   output logic [CNT_W-1:0]      count_o,
   output logic                  err_o,
   input  logic                  err_clr_i,
   output logic [15:0]           bursts_done_o
);

   localparam int PAY_W = r_payload_width(DATA_WIDTH, ID_WIDTH, USER_WIDTH);

   logic [PAY_W-1:0] wdata;
   logic [PAY_W-1:0] rdata;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             rdy_en_q;
   logic             err_q, err_d;
   logic [15:0]      bursts_q, bursts_d;

   // Ready comes only from registered state, never from slave_ready_i
   assign master_ready_o = rdy_en_q & ~full;
   assign slave_valid_o  = ~empty;
   assign push           = master_valid_i & master_ready_o;
   assign pop            = slave_valid_o & slave_ready_i;

   assign wdata = {master_data_i, master_resp_i, master_last_i, master_id_i, master_user_i};
   assign {slave_data_o, slave_resp_o, slave_last_o, slave_id_o, slave_user_o} = rdata;

   r_buffer_fifo #(
      .WIDTH (PAY_W),
      .DEPTH (BUFF_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .count_o (count_o),
      .full_o  (full),
      .empty_o (empty)
   );

   // A set in the same cycle as a clear takes priority
   always_comb begin
      err_d    = err_q;
      bursts_d = bursts_q;
      if (err_clr_i) err_d = 1'b0;
      if (push && (master_resp_i == RESP_SLVERR || master_resp_i == RESP_DECERR)) err_d = 1'b1;
      if (pop && slave_last_o) bursts_d = bursts_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdy_en_q <= 1'b0;
         err_q    <= 1'b0;
         bursts_q <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         err_q    <= err_d;
         bursts_q <= bursts_d;
      end
   end

   assign err_o         = err_q;
   assign bursts_done_o = bursts_q;

endmodule

`default_nettype wire
